ntt_ct_butterfly: RTL and testbench

Pipelined Cooley-Tukey (decimation-in-time) butterfly for the NewHope NTT datapath, q = 12289. Computes outa = (a + b*w) mod q and outb = (a - b*w) mod q, multiply first, then add/subtract.
It is the other-direction partner of the existing Gentleman-Sande butterfly, which adds/subtracts first and multiplies second. The NTT/INTT controllers instantiate it as a drop-in alternative with the same en/valid handshake.
Twiddle w arrives in Montgomery form (w*2^18 mod q), so the product is reduced by a built-in Montgomery reducer.

---
 rtl/ntt_ct_butterfly_pkg.sv | 20 ++
 rtl/ntt_ct_butterfly_if.sv | 23 ++
 rtl/ntt_mont_reduce.sv | 54 +++++
 rtl/ntt_ct_butterfly.sv | 103 ++++++++++
 tb/tb_ntt_ct_butterfly.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ntt_ct_butterfly_pkg.sv
// Shared constants and types for the NewHope NTT datapath (q = 12289).
// The halving helper is only used when NTT_CT_HALF_EN is defined.
package ntt_pkg;
  localparam int W    = 16;
  localparam int RLOG = 18;
  localparam int P_W  = 28;
  localparam int T_W  = 33;

  typedef logic [W-1:0] coeff_t;

  localparam coeff_t           Q    = 16'd12289;
  localparam logic [RLOG-1:0]  QINV = 18'd12287;

  // Multiply by 2^-1 mod Q: odd values are made even by adding Q first.
  function automatic coeff_t halve_mod(input coeff_t x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
    return coeff_t'(s >> 1);
  endfunction
endpackage

// File: rtl/ntt_ct_butterfly_if.sv
// Handshake/data bundle between an NTT controller and the CT butterfly.
// NTT_CT_HALF_EN adds the per-sample 'half' scaling flag.
interface ntt_ct_butterfly_if;
  import ntt_pkg::*;

  coeff_t ina;
  coeff_t inb;
  coeff_t omega;
  logic   in_valid;
  logic   en;
  coeff_t outa;
  coeff_t outb;
  logic   valid;
`ifdef NTT_CT_HALF_EN
  logic   half;

  modport master (output ina, inb, omega, in_valid, en, half, input outa, outb, valid);
  modport slave  (input ina, inb, omega, in_valid, en, half, output outa, outb, valid);
`else
  modport master (output ina, inb, omega, in_valid, en, input outa, outb, valid);
  modport slave  (input ina, inb, omega, in_valid, en, output outa, outb, valid);
`endif
endinterface

// File: rtl/ntt_mont_reduce.sv
// Two-stage Montgomery reducer: t = p * 2^-18 mod Q, result in [0,Q).
module ntt_mont_reduce
  import ntt_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [P_W-1:0] p,
  output coeff_t         t,
  output logic           out_valid
);
  logic [P_W-1:0]  p_d, p_q;
  logic [RLOG-1:0] m_d, m_q;
  logic            v3_d, v3_q;
  logic            v4_d, v4_q;
  logic [T_W-1:0]  sum_s;
  coeff_t          t_raw_s;
  coeff_t          t_d, t_q;

  // m makes p + m*Q divisible by 2^18; the low product bits are all that matter.
  always_comb begin
    p_d     = p;
    m_d     = p[RLOG-1:0] * QINV;
    v3_d    = in_valid;
    sum_s   = T_W'(p_q) + T_W'(m_q) * T_W'(Q);
    t_raw_s = W'(sum_s >> RLOG);
    if (t_raw_s >= Q) begin
      t_d = t_raw_s - Q;
    end else begin
      t_d = t_raw_s;
    end
    v4_d    = v3_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q  <= '0;
      m_q  <= '0;
      v3_q <= 1'b0;
      t_q  <= '0;
      v4_q <= 1'b0;
    end else if (en) begin
      p_q  <= p_d;
      m_q  <= m_d;
      v3_q <= v3_d;
      t_q  <= t_d;
      v4_q <= v4_d;
    end
  end

  assign t         = t_q;
  assign out_valid = v4_q;
endmodule

// File: rtl/ntt_ct_butterfly.sv
// 5-stage Cooley-Tukey butterfly: outa = a + b*w, outb = a - b*w (mod Q).
// Optional NTT_CT_HALF_EN scales both outputs by 2^-1 mod Q per sample.
module ntt_ct_butterfly
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ntt_ct_butterfly_if.slave  bus
);
  coeff_t         a1_q, b1_q, w1_q, a2_q, a3_q, a4_q;
  logic           v1_q, v2_q;
  logic [P_W-1:0] p2_d, p2_q;
  coeff_t         t4_s;
  logic           v4_s;
  logic [W:0]     sum_s;
  coeff_t         outa_d, outa_q, outb_d, outb_q;
  logic           v5_q;
`ifdef NTT_CT_HALF_EN
  logic           h1_q, h2_q, h3_q, h4_q, h5_q;
`endif

  ntt_mont_reduce u_reduce (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .in_valid  (v2_q),
    .p         (p2_q),
    .t         (t4_s),
    .out_valid (v4_s)
  );

  // Product and final modular add/sub; t < Q and a < Q keep each a single correction.
  always_comb begin
    p2_d  = P_W'(b1_q) * P_W'(w1_q);
    sum_s = {1'b0, a4_q} + {1'b0, t4_s};
    if (sum_s >= {1'b0, Q}) begin
      outa_d = W'(sum_s - {1'b0, Q});
    end else begin
      outa_d = W'(sum_s);
    end
    if (a4_q >= t4_s) begin
      outb_d = a4_q - t4_s;
    end else begin
      outb_d = a4_q + Q - t4_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a1_q   <= '0;
      b1_q   <= '0;
      w1_q   <= '0;
      v1_q   <= 1'b0;
      a2_q   <= '0;
      p2_q   <= '0;
      v2_q   <= 1'b0;
      a3_q   <= '0;
      a4_q   <= '0;
      outa_q <= '0;
      outb_q <= '0;
      v5_q   <= 1'b0;
    end else if (bus.en) begin
      a1_q   <= bus.ina;
      b1_q   <= bus.inb;
      w1_q   <= bus.omega;
      v1_q   <= bus.in_valid;
      a2_q   <= a1_q;
      p2_q   <= p2_d;
      v2_q   <= v1_q;
      a3_q   <= a2_q;
      a4_q   <= a3_q;
      outa_q <= outa_d;
      outb_q <= outb_d;
      v5_q   <= v4_s;
    end
  end

`ifdef NTT_CT_HALF_EN
  // Halve flag rides alongside the data; outa_q/outb_q hold the pre-halved values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
      h3_q <= 1'b0;
      h4_q <= 1'b0;
      h5_q <= 1'b0;
    end else if (bus.en) begin
      h1_q <= bus.half;
      h2_q <= h1_q;
      h3_q <= h2_q;
      h4_q <= h3_q;
      h5_q <= h4_q;
    end
  end

  assign bus.outa = h5_q ? halve_mod(outa_q) : outa_q;
  assign bus.outb = h5_q ? halve_mod(outb_q) : outb_q;
`else
  assign bus.outa = outa_q;
  assign bus.outb = outb_q;
`endif
  assign bus.valid = v5_q;
endmodule

// File: tb/tb_ntt_ct_butterfly.sv
// Scoreboard bench for ntt_ct_butterfly: random and directed samples vs. plain modular arithmetic.
module tb_ntt_ct_butterfly;
  import ntt_pkg::*;

  localparam int QI = 12289;
  localparam longint R_MOD = 4075;  // 2^18 mod Q

  typedef struct {
    int a;
    int b;
    int w;
    int ea;
    int eb;
    int due;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     en_cyc = 0;
  int     vcount = 0;
  int     vstart;
  logic   mon_en;
  logic [15:0] prev_a, prev_b;
  logic   prev_v;

  ntt_ct_butterfly_if bus ();

  ntt_ct_butterfly dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one sample with plain twiddle w; omega is its Montgomery form.
  task automatic drive(input int a, input int b, input int w);
    bus.ina      = 16'(a);
    bus.inb      = 16'(b);
    bus.omega    = 16'((longint'(w) * R_MOD) % QI);
    bus.in_valid = 1'b1;
  endtask

  task automatic push(input int a, input int b, input int w);
    exp_t e;
    longint bw;
    bw    = (longint'(b) * longint'(w)) % QI;
    e.a   = a;
    e.b   = b;
    e.w   = w;
    e.ea  = int'((longint'(a) + bw) % QI);
    e.eb  = int'(((longint'(a) - bw) % QI + QI) % QI);
    e.due = en_cyc + 5;
    sb.push_back(e);
  endtask

  task automatic send(input int a, input int b, input int w);
    @(negedge clk);
    drive(a, b, w);
    push(a, b, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: reset zeros, in-order results with exact latency, frozen outputs on stall.
  always @(posedge clk) begin
    exp_t e;
    mon_en = bus.en;
    #1;
    if (!reset) begin
      check("reset_outa", int'(bus.outa), 0);
      check("reset_outb", int'(bus.outb), 0);
      check("reset_valid", int'(bus.valid), 0);
    end else if (mon_en) begin
      en_cyc++;
      if (bus.valid) begin
        vcount++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("outa", int'(bus.outa), e.ea);
          check("outb", int'(bus.outb), e.eb);
          check("latency_edge", en_cyc, e.due);
        end
      end
    end else begin
      check("stall_outa_hold", int'(bus.outa), int'(prev_a));
      check("stall_outb_hold", int'(bus.outb), int'(prev_b));
      check("stall_valid_hold", int'(bus.valid), int'(prev_v));
    end
    prev_a = bus.outa;
    prev_b = bus.outb;
    prev_v = bus.valid;
  end

  initial begin
    reset        = 1'b0;
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.ina      = 16'd1;
    bus.inb      = 16'd2;
    bus.omega    = 16'd4075;
`ifdef NTT_CT_HALF_EN
    bus.half     = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Release with a valid sample already presented.
    reset = 1'b1;
    drive(100, 50, 1);
    push(100, 50, 1);
    send(5, 10, 1);
    send(12288, 12288, 1);
    send(0, 1, 1);
    send(7, 6000, 2);
    for (int i = 0; i < 16; i++) begin
      send(int'($urandom_range(QI - 1, 0)), int'($urandom_range(QI - 1, 0)),
           int'($urandom_range(QI - 1, 0)));
    end
    idle(1);
    drain();

    // Stall: the fifth sample is held on the bus while en = 0.
    vstart = vcount;
    for (int i = 0; i < 8; i++) begin
      int a, b, w;
      a = int'($urandom_range(QI - 1, 0));
      b = int'($urandom_range(QI - 1, 0));
      w = int'($urandom_range(QI - 1, 0));
      @(negedge clk);
      drive(a, b, w);
      if (i == 4) begin
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
      end
      push(a, b, w);
    end
    idle(1);
    drain();
    check("stall_valid_count", vcount - vstart, 8);

    // Mid-flight reset: three samples in the pipe are discarded.
    send(11, 22, 3);
    send(33, 44, 5);
    send(55, 66, 7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    sb.delete();
    vstart = vcount;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(8);
    check("flushed_no_valid", vcount - vstart, 0);
    send(1234, 4321, 99);
    idle(1);
    drain();
    check("post_reset_one_valid", vcount - vstart, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
